// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter
// Owns the register file's single write port. After reset it can zero-clear
// all 32 registers, one per cycle. In normal running it shares the port
// between core writeback and the external switch-input loader, which writes
// IO_REG. The write outputs are registered, so write latency is one cycle.
//
// Build option: define REGFILE_ARB_CLEAR_EN to enable the post-reset clear
// sequence. Without it, reset goes straight to RUN, busy_o is tied low, and
// the register array must reset itself.
module regfile_wport_arbiter #(
  parameter int DATA_W   = 32,
  parameter int IO_REG   = 25,
  parameter int MAX_WAIT = 4    // 1..15
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              wb_valid_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              wb_stall_o,
  input  logic              io_req_i,
  input  logic [DATA_W-1:0] io_data_i,
  output logic              io_ack_o,
  output logic              rf_we_o,
  output logic [4:0]        rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] last_wdata_o
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

`ifdef REGFILE_ARB_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = RUN;
`endif

  localparam logic [4:0] IO_ADDR = 5'(IO_REG);
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  // FSM and clear-sequence state
  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;

  // One-entry IO buffer plus its starvation tracking
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] pbuf_q, pbuf_d;
  logic [3:0]        wait_q, wait_d;
  logic              force_q, force_d;

  // Registered write-port outputs
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              io_ack_q, io_ack_d;
  logic [DATA_W-1:0] last_q, last_d;

  // Per-cycle issue decision
  logic              issue_io;
  logic              issue_wb;

  // Next-state logic: clear sequencing, IO capture and write-port arbitration
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    pbuf_d     = pbuf_q;
    wait_d     = wait_q;
    force_d    = force_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    io_ack_d   = 1'b0;
    last_d     = last_q;
    issue_io   = 1'b0;
    issue_wb   = 1'b0;

    case (state_q)
      CLEAR: begin
        // One zero write per cycle. Requests are ignored, so nothing is
        // captured while the sequence runs.
        rf_we_d    = 1'b1;
        rf_waddr_d = cnt_q;
        rf_wdata_d = '0;
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = RUN;
        end
      end

      RUN: begin
        // io_ack_q blocks a re-capture of the request that was just
        // acknowledged, before the requester has had a chance to drop it.
        if (io_req_i && !pending_q && !io_ack_q) begin
          pending_d = 1'b1;
          pbuf_d    = io_data_i;
        end

        // A forced IO write beats the core. Otherwise the core wins, and a
        // buffered IO write fills any idle slot.
        if (force_q && pending_q) begin
          issue_io = 1'b1;
        end else if (wb_valid_i) begin
          issue_wb = 1'b1;
        end else if (pending_q) begin
          issue_io = 1'b1;
        end

        if (issue_wb) begin
          // Writes to r0 are consumed but never reach the array.
          rf_we_d    = (wb_addr_i != 5'd0);
          rf_waddr_d = wb_addr_i;
          rf_wdata_d = wb_data_i;
          if (pending_q && (wait_q != WAIT_LIM)) begin
            wait_d = wait_q + 4'd1;
            if ((wait_q + 4'd1) == WAIT_LIM) begin
              force_d = 1'b1;
            end
          end
        end

        if (issue_io) begin
          rf_we_d    = (IO_ADDR != 5'd0);
          rf_waddr_d = IO_ADDR;
          rf_wdata_d = pbuf_q;
          io_ack_d   = 1'b1;
          pending_d  = 1'b0;
          wait_d     = '0;
          force_d    = 1'b0;
        end

        // Clear writes do not update last_wdata; only real writes do.
        if (rf_we_d) begin
          last_d = rf_wdata_d;
        end
      end

      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      pbuf_q     <= '0;
      wait_q     <= '0;
      force_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      io_ack_q   <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      pbuf_q     <= pbuf_d;
      wait_q     <= wait_d;
      force_q    <= force_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      io_ack_q   <= io_ack_d;
      last_q     <= last_d;
    end
  end

  // The stall depends only on registers, so the core sees it early in the cycle.
  assign wb_stall_o   = force_q & pending_q & (state_q == RUN);

`ifdef REGFILE_ARB_CLEAR_EN
  assign busy_o       = (state_q == CLEAR);
`else
  assign busy_o       = 1'b0;
`endif

  assign io_ack_o     = io_ack_q;
  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign last_wdata_o = last_q;

endmodule
